tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the tiny-tdc datapath.
- Arms on a start edge, counts coarse clk cycles and ring-oscillator pulses until a stop edge or a timeout, then streams a fixed result frame byte-by-byte into the Uart block.
- Uses the Uart's valid/ready/data byte interface.
- Sits between the pad inputs (start, stop), ring_oscillator o_pulse and Uart, replacing the constant axi_data/axi_valid tie-offs in the top level.

Parameters:
COUNT_W, 16, coarse counter width in bits; must be a multiple of 8, minimum 8
FINE_W, 8, ring-pulse counter width; fixed at 8 (one frame byte)
SYNC_STAGES, 2, flip-flop stages per asynchronous input synchronizer, minimum 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  asynchronous start pin
stop  input  1  asynchronous stop pin
ring_pulse  input  1  ring_oscillator o_pulse, asynchronous to clk
axi_valid  output  1  result byte valid to Uart
axi_ready  input  1  Uart accepts byte when high together with axi_valid
axi_data  output  8  result byte
busy  output  1  high in any state other than IDLE
meas_done  output  1  one-cycle pulse on handshake of the final frame byte

Behaviour:
- Reset values (asynchronous): state IDLE; all counters and flags 0; axi_valid 0; axi_data 0x00; busy 0; meas_done 0. Reset mid-frame drops axi_valid immediately and discards the frame.
- Input conditioning: start, stop and ring_pulse each pass through SYNC_STAGES flip-flops, then a registered rising-edge detect. ring_pulse must be at most clk/4 for exact counting.
- States:
  - IDLE: start edge -> RUN, clearing coarse, fine and flags. A stop edge in IDLE is ignored. If start and stop edges arrive together, start wins and the stop is ignored.
  - RUN: coarse increments by 1 every cycle. Each ring edge increments fine. If a stop edge is detected at cycle t0+N after the start detect at t0, latch coarse=N and go to SEND. Start edges are ignored. fine saturates at 0xFF and sets fine_ovf. If coarse would exceed 2^COUNT_W-1, it holds all-ones, sets timeout, and goes to SEND.
  - SEND: frame bytes in order:
    - header 0xA5
    - coarse, COUNT_W/8 bytes, MSB first
    - fine
    - status {6'b0, timeout, fine_ovf}
    - checksum byte only with TDC_CHECKSUM_EN
    axi_valid is high for the whole of SEND. axi_data advances only on valid&&ready and stays stable otherwise. After the last byte's handshake, meas_done pulses and the block goes to REARM. Start/stop/ring edges are ignored in SEND.
  - REARM: wait until synchronized start is low, then IDLE. A held-high start never retriggers.
- Latency: axi_valid rises on the cycle after stop detection, which is SYNC_STAGES+2 clk cycles after the stop pin rises (setup met). A zero-wait Uart drains the frame in one byte per cycle from this block's side.

Optional Feature:
TDC_CHECKSUM_EN
- Defined: one extra byte follows status, equal to the XOR of all preceding frame bytes, header included.
- Undefined: the frame ends at status and no checksum logic is synthesized.

Decomposition:
- Package tdc_pkg:
  - state enum (IDLE, RUN, SEND, REARM)
  - TDC_HEADER = 8'hA5
  - status bit indices STAT_FINE_OVF=0, STAT_TIMEOUT=1
  - frame-length function of COUNT_W
- Sub-module tdc_sync_edge: SYNC_STAGES synchronizer plus rising-edge pulse, parameterized by stages, async active-high rst. Instantiated three times.

Test Plan:
1. Start rise; 7 ring edges at clk/10; stop detected 100 cycles after start detect; axi_ready held 1.
   -> bytes A5 00 64 07 00 (+C6 with TDC_CHECKSUM_EN); meas_done pulses once; busy returns 0 after start falls.
2. Start rise, no stop.
   -> after 65535 RUN cycles, frame A5 FF FF <fine> 02.
3. 300 ring edges before stop.
   -> fine byte FF, status 01.
4. During case 1, axi_ready low for 20 cycles on the header byte.
   -> axi_valid stays 1, axi_data stays A5 with no byte skipped; remaining bytes follow correctly.
5. Start and stop rise together in IDLE, then stop again 50 cycles later.
   -> coarse 0x0032.
   Stop pulse alone in IDLE -> no frame.
   Start held high through the frame -> no second measurement.
6. Assert rst during the second frame byte.
   -> axi_valid 0 the same cycle; a following measurement produces a clean frame starting with A5.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and constants for the tdc measurement sequencer.
// Optional feature macro: TDC_CHECKSUM_EN (appends an XOR checksum byte to the frame).
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SEND  = 2'd2,
    REARM = 2'd3
  } tdc_state_e;

  localparam logic [7:0] TDC_HEADER = 8'hA5;

  localparam int STAT_FINE_OVF = 0;
  localparam int STAT_TIMEOUT  = 1;

  // Header + coarse bytes + fine + status (+ checksum).
  function automatic int frame_len(input int count_w);
`ifdef TDC_CHECKSUM_EN
    return 4 + count_w / 8;
`else
    return 3 + count_w / 8;
`endif
  endfunction

endpackage

// File: rtl/tdc_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin followed by a registered
// rising-edge pulse; also exposes the synchronized level.
module tdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d};
      level_d <= sync_q[STAGES-1];
      rise    <= sync_q[STAGES-1] & ~level_d;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: start edge arms, counts coarse cycles and ring pulses
// until stop or timeout, then streams a result frame over valid/ready.
// Optional feature macro: TDC_CHECKSUM_EN (XOR checksum byte after status).
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int FINE_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       ring_pulse,
  output logic       axi_valid,
  input  logic       axi_ready,
  output logic [7:0] axi_data,
  output logic       busy,
  output logic       meas_done
);

  localparam int CB    = COUNT_W / 8;
  localparam int FLEN  = frame_len(COUNT_W);
  localparam int IDX_W = $clog2(FLEN);

  localparam logic [IDX_W-1:0]   IDX_FINE   = IDX_W'(CB + 1);
  localparam logic [IDX_W-1:0]   IDX_STAT   = IDX_W'(CB + 2);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(FLEN - 1);
  localparam logic [COUNT_W-1:0] COARSE_MAX = '1;

  // Handshake: a byte transfers on a cycle where axi_valid && axi_ready are
  // both high; axi_data is held unchanged while axi_valid && !axi_ready.

  logic start_lvl, start_edge;
  logic stop_lvl, stop_edge;
  logic ring_lvl, ring_edge;
  logic unused_lvl;

  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk(clk), .rst(rst), .d(start), .level(start_lvl), .rise(start_edge)
  );
  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_stop_sync (
    .clk(clk), .rst(rst), .d(stop), .level(stop_lvl), .rise(stop_edge)
  );
  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_ring_sync (
    .clk(clk), .rst(rst), .d(ring_pulse), .level(ring_lvl), .rise(ring_edge)
  );

  assign unused_lvl = stop_lvl ^ ring_lvl;

  tdc_state_e           state, state_n;
  logic [COUNT_W-1:0]   coarse;
  logic [FINE_W-1:0]    fine;
  logic                 timeout;
  logic                 fine_ovf;
  logic [IDX_W-1:0]     idx;
  logic                 hs;
  logic                 last_byte;
  logic [7:0]           status_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    axi_valid = (state == SEND);
    busy      = (state != IDLE);
    hs        = axi_valid && axi_ready;
    last_byte = (idx == IDX_LAST);
    meas_done = hs && last_byte;
    case (state)
      IDLE:    if (start_edge) state_n = RUN;
      RUN:     if (stop_edge || coarse == COARSE_MAX) state_n = SEND;
      SEND:    if (hs && last_byte) state_n = REARM;
      REARM:   if (!start_lvl) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A stop landing on the saturated count is reported as a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse   <= '0;
      fine     <= '0;
      timeout  <= 1'b0;
      fine_ovf <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            coarse   <= '0;
            fine     <= '0;
            timeout  <= 1'b0;
            fine_ovf <= 1'b0;
            idx      <= '0;
          end
        end
        RUN: begin
          if (coarse == COARSE_MAX) timeout <= 1'b1;
          else                      coarse  <= coarse + COUNT_W'(1);
          if (ring_edge) begin
            if (fine == '1) fine_ovf <= 1'b1;
            else            fine     <= fine + FINE_W'(1);
          end
        end
        SEND: begin
          if (hs && !last_byte) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status_byte                = 8'h00;
    status_byte[STAT_TIMEOUT]  = timeout;
    status_byte[STAT_FINE_OVF] = fine_ovf;
  end

`ifdef TDC_CHECKSUM_EN
  localparam logic [IDX_W-1:0] IDX_CHK = IDX_W'(CB + 3);
  logic [7:0] checksum;

  always_comb begin
    checksum = TDC_HEADER ^ fine ^ status_byte;
    for (int i = 0; i < CB; i++) checksum = checksum ^ coarse[i*8 +: 8];
  end
`endif

  // Coarse count goes out most-significant byte first.
  always_comb begin
    axi_data = 8'h00;
    if (state == SEND) begin
      if (idx == '0) axi_data = TDC_HEADER;
      for (int i = 0; i < CB; i++) begin
        if (idx == IDX_W'(i + 1)) axi_data = coarse[(CB-1-i)*8 +: 8];
      end
      if (idx == IDX_FINE) axi_data = fine;
      if (idx == IDX_STAT) axi_data = status_byte;
`ifdef TDC_CHECKSUM_EN
      if (idx == IDX_CHK) axi_data = checksum;
`endif
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomized self-checking bench for tdc_meas_ctrl with a frame-level model.
// Build with TDC_CHECKSUM_EN defined to also cover the checksum byte.
module tb_tdc_meas_ctrl;

  localparam int COUNT_W = 16;
  localparam int SYNC    = 2;
  localparam int CB      = COUNT_W / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ring_pulse = 1'b0;
  logic       axi_ready = 1'b0;
  logic       axi_valid;
  logic [7:0] axi_data;
  logic       busy;
  logic       meas_done;

  tdc_meas_ctrl #(.COUNT_W(COUNT_W), .FINE_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ring_pulse(ring_pulse),
    .axi_valid(axi_valid), .axi_ready(axi_ready), .axi_data(axi_data),
    .busy(busy), .meas_done(meas_done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         rdy_rand = 1'b0;
  int         done_cnt = 0;
  int         valid_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame predicted from the measured interval and number of ring pulses.
  task automatic model_frame(input longint n, input int cnt);
    longint             cmax;
    logic [COUNT_W-1:0] c;
    logic               to, ovf;
    logic [7:0]         f, st, x, b;
    cmax = (64'd1 << COUNT_W) - 1;
    to   = (n > cmax);
    c    = to ? {COUNT_W{1'b1}} : COUNT_W'(n);
    ovf  = (cnt > 255);
    f    = ovf ? 8'hFF : 8'(cnt);
    st   = {6'b0, to, ovf};
    x    = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = CB - 1; i >= 0; i--) begin
      b = c[i*8 +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(f);
    exp_q.push_back(st);
    x = x ^ f ^ st;
`ifdef TDC_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) axi_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (axi_valid) valid_cnt++;
      if (prev_stall && axi_valid) chk("hold", axi_data, prev_data);
      if (axi_valid && axi_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("byte", axi_data, e);
          chk("done", meas_done, exp_q.size() == 0);
          if (meas_done) done_cnt++;
        end
      end else if (meas_done) begin
        chk("done_spur", meas_done, 0);
      end
      prev_stall = axi_valid && !axi_ready;
      prev_data  = axi_data;
    end
  end

  // Start rises now; stop rises n cycles later (n > 65535 means no stop).
  task automatic start_meas(input int n, input int cnt, input int per, input bit both);
    int el;
    int lat;
    model_frame(n, cnt);
    done_cnt = 0;
    start = 1'b1;
    if (both) stop = 1'b1;
    tick(5);
    stop = 1'b0;
    tick(1);
    el = 6;
    for (int k = 0; k < cnt; k++) begin
      ring_pulse = 1'b1;
      tick(per / 2);
      ring_pulse = 1'b0;
      tick(per - per / 2);
      el += per;
    end
    if (n <= 65535) begin
      tick(n - el);
      stop = 1'b1;
      lat = 0;
      while (!axi_valid && lat < 20) begin
        tick(1);
        lat++;
      end
      chk("latency", lat, SYNC + 2);
      stop = 1'b0;
    end
  endtask

  task automatic finish_meas(input int budget);
    int w;
    w = 0;
    while (!(exp_q.size() == 0 && !axi_valid) && w < budget) begin
      tick(1);
      w++;
    end
    chk("frame_left", exp_q.size(), 0);
    chk("done_once", done_cnt, 1);
    tick(10);
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_valid", axi_valid, 1'b0);
    start = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      tick(1);
      w++;
    end
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int n, per, cnt, snap;

    tick(3);
    chk("rst_valid", axi_valid, 1'b0);
    chk("rst_data", axi_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", meas_done, 1'b0);
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // Basic measurement, zero-wait sink.
    axi_ready = 1'b1;
    start_meas(100, 7, 10, 1'b0);
    finish_meas(200);

    // Header stalled for 20 cycles.
    axi_ready = 1'b0;
    start_meas(100, 7, 10, 1'b0);
    repeat (20) begin
      chk("stall_valid", axi_valid, 1'b1);
      chk("stall_data", axi_data, 8'hA5);
      tick(1);
    end
    axi_ready = 1'b1;
    finish_meas(200);

    // Fine counter saturation.
    start_meas(1300, 300, 4, 1'b0);
    finish_meas(200);

    // Simultaneous start/stop: start wins, second stop 50 cycles later.
    start_meas(50, 0, 4, 1'b1);
    finish_meas(200);

    // Lone stop in idle produces nothing.
    snap = valid_cnt;
    stop = 1'b1;
    tick(5);
    stop = 1'b0;
    tick(20);
    chk("stop_only_busy", busy, 1'b0);
    chk("stop_only_valid", valid_cnt - snap, 0);

    // Randomized measurements with random sink back-pressure.
    rdy_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      n   = $urandom_range(20, 600);
      per = $urandom_range(4, 10);
      cnt = $urandom_range(0, (n - 12) / per);
      start_meas(n, cnt, per, 1'b0);
      finish_meas(400);
    end

    // Reset while the second frame byte is presented.
    rdy_rand  = 1'b0;
    axi_ready = 1'b0;
    start_meas(40, 2, 6, 1'b0);
    axi_ready = 1'b1;
    tick(1);
    axi_ready = 1'b0;
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", axi_valid, 1'b0);
    chk("midrst_data", axi_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    exp_q.delete();
    start = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;
    axi_ready = 1'b1;
    start_meas(60, 3, 5, 1'b0);
    finish_meas(200);

    // Timeout: no stop ever arrives.
    rdy_rand = 1'b1;
    start_meas(70000, 5, 6, 1'b0);
    finish_meas(70000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
